// File: rtl/issue_queue_pkg.sv
// rtl/issue_queue_pkg.sv - shared types and operand-usage helpers for the issue queue
package issue_queue_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned RW   = $clog2(NREG);

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_e;

    typedef enum logic {UNIT_ALU, UNIT_LSU} issue_unit_e;

    typedef enum logic [1:0] {SEL_A_REG, SEL_A_PC, SEL_A_ZERO} op_a_sel_e;

    typedef enum logic {SEL_B_REG, SEL_B_IMM} op_b_sel_e;

    typedef struct packed {
        logic [RW-1:0]   rs1;
        logic [RW-1:0]   rs2;
        logic [RW-1:0]   rd;
        logic            we;
        issue_unit_e     unit;
        alu_op_e         alu_op;
        op_a_sel_e       sel_a;
        op_b_sel_e       sel_b;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } issue_entry_t;

    // LSU ops always read rs1 as the base; ALU ops only when operand A is a register.
    function automatic logic reads_rs1(issue_entry_t e);
        return (e.unit == UNIT_LSU) || (e.sel_a == SEL_A_REG);
    endfunction

    // LSU stores (no register write) read rs2 as write data; ALU ops only for a register operand B.
    function automatic logic reads_rs2(issue_entry_t e);
        return (e.unit == UNIT_LSU) ? !e.we : (e.sel_b == SEL_B_REG);
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - pending-write bit per architectural register
module issue_scoreboard #(
    parameter  int unsigned NREG = 32,
    localparam int unsigned RW   = $clog2(NREG)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          set_valid_i,
    input  logic [RW-1:0] set_rd_i,
    input  logic          clr_valid_i,
    input  logic [RW-1:0] clr_rd_i,
    input  logic [RW-1:0] rs1_i,
    input  logic [RW-1:0] rs2_i,
    input  logic [RW-1:0] rd_i,
    output logic          rs1_busy_o,
    output logic          rs2_busy_o,
    output logic          rd_busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Clear first so a same-cycle set of the same register wins; x0 is never busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_valid_i) busy_d[clr_rd_i] = 1'b0;
        if (set_valid_i) busy_d[set_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign rs1_busy_o = busy_q[rs1_i];
    assign rs2_busy_o = busy_q[rs2_i];
    assign rd_busy_o  = busy_q[rd_i];

endmodule

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - in-order issue queue with scoreboard and ALU/LSU dispatch
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            dec_valid_i,
    output logic            dec_ready_o,
    input  issue_entry_t    dec_entry_i,
    output logic [RW-1:0]   rf_raddr_a_o,
    output logic [RW-1:0]   rf_raddr_b_o,
    input  logic [XLEN-1:0] rf_rdata_a_i,
    input  logic [XLEN-1:0] rf_rdata_b_i,
    output logic            alu_valid_o,
    input  logic            alu_ready_i,
    output alu_op_e         alu_op_o,
    output logic [XLEN-1:0] alu_operand_a_o,
    output logic [XLEN-1:0] alu_operand_b_o,
    output logic [RW-1:0]   alu_rd_o,
    output logic            lsu_valid_o,
    input  logic            lsu_ready_i,
    output logic            lsu_we_o,
    output logic [XLEN-1:0] lsu_base_o,
    output logic [XLEN-1:0] lsu_offset_o,
    output logic [XLEN-1:0] lsu_wdata_o,
    output logic [RW-1:0]   lsu_rd_o,
    input  logic            wb_valid_i,
    input  logic [RW-1:0]   wb_rd_i,
    output logic [CW-1:0]   count_o
);

    issue_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    issue_entry_t head;
    logic         empty, push, pop, head_ready;
    logic         rs1_busy, rs2_busy, rd_busy;

    assign empty       = (count_q == '0);
    assign dec_ready_o = (count_q != CW'(DEPTH));
    assign push        = dec_valid_i && dec_ready_o && !flush_i;
    assign head        = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o     = count_q;

    assign rf_raddr_a_o = head.rs1;
    assign rf_raddr_b_o = head.rs2;

    issue_scoreboard #(.NREG(NREG)) u_sb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .set_valid_i (pop && head.we),
        .set_rd_i    (head.rd),
        .clr_valid_i (wb_valid_i),
        .clr_rd_i    (wb_rd_i),
        .rs1_i       (head.rs1),
        .rs2_i       (head.rs2),
        .rd_i        (head.rd),
        .rs1_busy_o  (rs1_busy),
        .rs2_busy_o  (rs2_busy),
        .rd_busy_o   (rd_busy)
    );

    assign head_ready = !empty
                     && !(reads_rs1(head) && rs1_busy)
                     && !(reads_rs2(head) && rs2_busy)
                     && !(head.we && rd_busy);

    assign alu_valid_o = head_ready && (head.unit == UNIT_ALU);
    assign lsu_valid_o = head_ready && (head.unit == UNIT_LSU);
    assign pop         = (alu_valid_o && alu_ready_i) || (lsu_valid_o && lsu_ready_i);

    // Operand resolution for the head; everything reads as zero while the queue is empty.
    always_comb begin
        alu_op_o        = ALU_ADD;
        alu_operand_a_o = '0;
        alu_operand_b_o = '0;
        alu_rd_o        = '0;
        lsu_we_o        = 1'b0;
        lsu_base_o      = '0;
        lsu_offset_o    = '0;
        lsu_wdata_o     = '0;
        lsu_rd_o        = '0;
        if (!empty) begin
            case (head.sel_a)
                SEL_A_REG: alu_operand_a_o = rf_rdata_a_i;
                SEL_A_PC:  alu_operand_a_o = head.pc;
                default:   alu_operand_a_o = '0;
            endcase
            alu_operand_b_o = (head.sel_b == SEL_B_IMM) ? head.imm : rf_rdata_b_i;
            alu_op_o        = head.alu_op;
            alu_rd_o        = head.rd;
            // An LSU op that writes no register is a store.
            lsu_we_o        = !head.we;
            lsu_base_o      = rf_rdata_a_i;
            lsu_offset_o    = head.imm;
            lsu_wdata_o     = rf_rdata_b_i;
            lsu_rd_o        = head.rd;
        end
    end

    // Pointer and occupancy next state; flush empties the queue and drops any push.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below count_q, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= dec_entry_i;
    end

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - self-checking bench for issue_queue
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_i, flush_i, dec_valid_i, dec_ready_o;
    issue_entry_t    dec_entry_i;
    logic [RW-1:0]   rf_raddr_a_o, rf_raddr_b_o;
    logic [XLEN-1:0] rf_rdata_a_i, rf_rdata_b_i;
    logic            alu_valid_o, alu_ready_i;
    alu_op_e         alu_op_o;
    logic [XLEN-1:0] alu_operand_a_o, alu_operand_b_o;
    logic [RW-1:0]   alu_rd_o;
    logic            lsu_valid_o, lsu_ready_i, lsu_we_o;
    logic [XLEN-1:0] lsu_base_o, lsu_offset_o, lsu_wdata_o;
    logic [RW-1:0]   lsu_rd_o;
    logic            wb_valid_i;
    logic [RW-1:0]   wb_rd_i;
    logic [2:0]      count_o;

    logic [XLEN-1:0] rf [NREG];
    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    assign rf_rdata_a_i = rf[rf_raddr_a_o];
    assign rf_rdata_b_i = rf[rf_raddr_b_o];

    issue_queue #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o), .dec_entry_i(dec_entry_i),
        .rf_raddr_a_o(rf_raddr_a_o), .rf_raddr_b_o(rf_raddr_b_o),
        .rf_rdata_a_i(rf_rdata_a_i), .rf_rdata_b_i(rf_rdata_b_i),
        .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i), .alu_op_o(alu_op_o),
        .alu_operand_a_o(alu_operand_a_o), .alu_operand_b_o(alu_operand_b_o), .alu_rd_o(alu_rd_o),
        .lsu_valid_o(lsu_valid_o), .lsu_ready_i(lsu_ready_i), .lsu_we_o(lsu_we_o),
        .lsu_base_o(lsu_base_o), .lsu_offset_o(lsu_offset_o), .lsu_wdata_o(lsu_wdata_o),
        .lsu_rd_o(lsu_rd_o), .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .count_o(count_o)
    );

    function automatic issue_entry_t mk(int rs1, int rs2, int rd, bit we, issue_unit_e u,
                                        alu_op_e op, op_a_sel_e sa, op_b_sel_e sb, logic [31:0] imm);
        issue_entry_t e;
        e.rs1 = RW'(rs1); e.rs2 = RW'(rs2); e.rd = RW'(rd); e.we = we; e.unit = u;
        e.alu_op = op; e.sel_a = sa; e.sel_b = sb; e.imm = imm; e.pc = 32'h400;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        flush_i = 0; dec_valid_i = 0; dec_entry_i = '0; alu_ready_i = 0; lsu_ready_i = 0;
        wb_valid_i = 0; wb_rd_i = '0; rst_i = 1;
        tick();
        rst_i = 0;
    endtask

    task automatic test_reset();
        do_reset();
        alu_ready_i = 1;
        dec_valid_i = 1; dec_entry_i = mk(1, 2, 9, 1, UNIT_ALU, ALU_ADD, SEL_A_REG, SEL_B_REG, 0);
        tick();
        dec_valid_i = 0; tick();
        alu_ready_i = 0; dec_valid_i = 1; dec_entry_i = mk(1, 2, 8, 1, UNIT_ALU, ALU_OR, SEL_A_REG, SEL_B_REG, 0);
        tick(); tick();
        dec_valid_i = 0; rst_i = 1;
        tick();
        rst_i = 0; settle();
        checks++; if (count_o !== 3'd0) $display("FAIL reset_count: got %0d want 0", count_o); else passes++;
        checks++; if (dec_ready_o !== 1'b1) $display("FAIL reset_dec_ready: got %0b want 1", dec_ready_o); else passes++;
        checks++; if ({alu_valid_o, lsu_valid_o} !== 2'b00) $display("FAIL reset_valids: got %b want 00", {alu_valid_o, lsu_valid_o}); else passes++;
        checks++; if (dut.u_sb.busy_q !== '0) $display("FAIL reset_scoreboard: got %h want 0", dut.u_sb.busy_q); else passes++;
        checks++; if ({rf_raddr_a_o, rf_raddr_b_o, alu_operand_a_o, alu_operand_b_o, lsu_base_o} !== '0)
            $display("FAIL reset_data_zero: got %h want 0", {rf_raddr_a_o, rf_raddr_b_o, alu_operand_a_o, alu_operand_b_o, lsu_base_o}); else passes++;
    endtask

    task automatic test_basic_add();
        do_reset();
        rf[1] = 5; rf[2] = 7; alu_ready_i = 1;
        dec_valid_i = 1; dec_entry_i = mk(1, 2, 3, 1, UNIT_ALU, ALU_ADD, SEL_A_REG, SEL_B_REG, 0);
        settle();
        checks++; if (alu_valid_o !== 1'b0) $display("FAIL add_no_passthrough: got %0b want 0", alu_valid_o); else passes++;
        tick();
        dec_valid_i = 0; settle();
        checks++; if (alu_valid_o !== 1'b1) $display("FAIL add_valid: got %0b want 1", alu_valid_o); else passes++;
        checks++; if (alu_operand_a_o !== 32'd5 || alu_operand_b_o !== 32'd7)
            $display("FAIL add_operands: got %0d/%0d want 5/7", alu_operand_a_o, alu_operand_b_o); else passes++;
        checks++; if (alu_rd_o !== 5'd3 || alu_op_o !== ALU_ADD) $display("FAIL add_rd_op: got %0d/%0d want 3/0", alu_rd_o, alu_op_o); else passes++;
        tick();
        checks++; if (dut.u_sb.busy_q[3] !== 1'b1) $display("FAIL add_sb_set: got %0b want 1", dut.u_sb.busy_q[3]); else passes++;
        checks++; if (count_o !== 3'd0) $display("FAIL add_count_after: got %0d want 0", count_o); else passes++;
    endtask

    task automatic test_raw();
        do_reset();
        rf[1] = 5; rf[2] = 7; rf[3] = 32'h33; alu_ready_i = 1;
        dec_valid_i = 1; dec_entry_i = mk(1, 2, 3, 1, UNIT_ALU, ALU_ADD, SEL_A_REG, SEL_B_REG, 0);
        tick();
        dec_entry_i = mk(3, 2, 4, 1, UNIT_ALU, ALU_SUB, SEL_A_REG, SEL_B_REG, 0);
        settle();
        checks++; if (alu_valid_o !== 1'b1 || alu_rd_o !== 5'd3) $display("FAIL raw_first_issue: got %0b/%0d want 1/3", alu_valid_o, alu_rd_o); else passes++;
        tick();
        dec_valid_i = 0;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++; if (alu_valid_o !== 1'b0) $display("FAIL raw_stall%0d: got %0b want 0", i, alu_valid_o); else passes++;
            tick();
        end
        wb_valid_i = 1; wb_rd_i = 3; settle();
        checks++; if (alu_valid_o !== 1'b0) $display("FAIL raw_stall_wb_cycle: got %0b want 0", alu_valid_o); else passes++;
        tick();
        wb_valid_i = 0; settle();
        checks++; if (alu_valid_o !== 1'b1 || alu_op_o !== ALU_SUB || alu_operand_a_o !== 32'h33)
            $display("FAIL raw_release: got %0b/%0d/%h want 1/1/33", alu_valid_o, alu_op_o, alu_operand_a_o); else passes++;
        tick();
        checks++; if (dut.u_sb.busy_q[4:3] !== 2'b10) $display("FAIL raw_sb: got %b want 10", dut.u_sb.busy_q[4:3]); else passes++;
    endtask

    task automatic test_fill();
        do_reset();
        rf[1] = 1;
        dec_valid_i = 1;
        for (int i = 0; i < 4; i++) begin
            dec_entry_i = mk(1, 0, 10 + i, 1, UNIT_ALU, ALU_OR, SEL_A_REG, SEL_B_IMM, 100 + i);
            tick();
        end
        dec_entry_i = mk(1, 0, 20, 1, UNIT_ALU, ALU_OR, SEL_A_REG, SEL_B_IMM, 999);
        settle();
        checks++; if (dec_ready_o !== 1'b0 || count_o !== 3'd4) $display("FAIL fill_full: got %0b/%0d want 0/4", dec_ready_o, count_o); else passes++;
        tick();
        dec_valid_i = 0; settle();
        checks++; if (count_o !== 3'd4) $display("FAIL fill_fifth_ignored: got %0d want 4", count_o); else passes++;
        alu_ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (alu_valid_o !== 1'b1 || alu_rd_o !== RW'(10 + i) || alu_operand_b_o !== 32'(100 + i) || count_o !== 3'(4 - i))
                $display("FAIL fill_drain%0d: got %0b/%0d/%0d/%0d want 1/%0d/%0d/%0d", i, alu_valid_o, alu_rd_o, alu_operand_b_o, count_o, 10 + i, 100 + i, 4 - i);
            else passes++;
            tick();
        end
        settle();
        checks++; if (count_o !== 3'd0 || alu_valid_o !== 1'b0) $display("FAIL fill_empty: got %0d/%0b want 0/0", count_o, alu_valid_o); else passes++;
    endtask

    task automatic test_lsu_store();
        do_reset();
        rf[4] = 32'h1000; rf[6] = 32'hAB; alu_ready_i = 1; lsu_ready_i = 1;
        dec_valid_i = 1; dec_entry_i = mk(4, 6, 0, 0, UNIT_LSU, ALU_ADD, SEL_A_REG, SEL_B_IMM, 32'h10);
        tick();
        dec_valid_i = 0; settle();
        checks++; if (lsu_valid_o !== 1'b1 || alu_valid_o !== 1'b0) $display("FAIL lsu_valids: got %0b/%0b want 1/0", lsu_valid_o, alu_valid_o); else passes++;
        checks++; if (lsu_base_o !== 32'h1000 || lsu_offset_o !== 32'h10 || lsu_wdata_o !== 32'hAB || lsu_we_o !== 1'b1)
            $display("FAIL lsu_data: got %h/%h/%h/%0b want 1000/10/ab/1", lsu_base_o, lsu_offset_o, lsu_wdata_o, lsu_we_o); else passes++;
        tick();
        checks++; if (dut.u_sb.busy_q !== '0 || count_o !== 3'd0) $display("FAIL lsu_no_sb: got %h/%0d want 0/0", dut.u_sb.busy_q, count_o); else passes++;
    endtask

    task automatic test_flush();
        do_reset();
        alu_ready_i = 1;
        dec_valid_i = 1; dec_entry_i = mk(1, 2, 7, 1, UNIT_ALU, ALU_ADD, SEL_A_REG, SEL_B_REG, 0);
        tick();
        dec_valid_i = 0; tick();
        alu_ready_i = 0; dec_valid_i = 1;
        for (int i = 0; i < 3; i++) begin
            dec_entry_i = mk(0, 0, 8 + i, 1, UNIT_ALU, ALU_ADD, SEL_A_ZERO, SEL_B_IMM, i);
            tick();
        end
        flush_i = 1; dec_entry_i = mk(0, 0, 12, 1, UNIT_ALU, ALU_ADD, SEL_A_ZERO, SEL_B_IMM, 0);
        settle();
        checks++; if (count_o !== 3'd3) $display("FAIL flush_pre_count: got %0d want 3", count_o); else passes++;
        tick();
        flush_i = 0; dec_valid_i = 0; settle();
        checks++; if (count_o !== 3'd0 || {alu_valid_o, lsu_valid_o} !== 2'b00)
            $display("FAIL flush_empty: got %0d/%b want 0/00", count_o, {alu_valid_o, lsu_valid_o}); else passes++;
        checks++; if (dut.u_sb.busy_q !== 32'h80) $display("FAIL flush_sb_kept: got %h want 80", dut.u_sb.busy_q); else passes++;
    endtask

    task automatic test_set_clear();
        do_reset();
        rf[0] = 0; alu_ready_i = 1;
        dec_valid_i = 1; dec_entry_i = mk(1, 2, 5, 1, UNIT_ALU, ALU_ADD, SEL_A_REG, SEL_B_REG, 0);
        tick();
        dec_valid_i = 0; wb_valid_i = 1; wb_rd_i = 5; settle();
        checks++; if (alu_valid_o !== 1'b1) $display("FAIL setclr_issue: got %0b want 1", alu_valid_o); else passes++;
        tick();
        wb_valid_i = 0;
        checks++; if (dut.u_sb.busy_q[5] !== 1'b1) $display("FAIL setclr_set_wins: got %0b want 1", dut.u_sb.busy_q[5]); else passes++;
        dec_valid_i = 1; dec_entry_i = mk(1, 2, 0, 1, UNIT_ALU, ALU_ADD, SEL_A_REG, SEL_B_REG, 0);
        tick();
        dec_entry_i = mk(0, 0, 6, 1, UNIT_ALU, ALU_XOR, SEL_A_REG, SEL_B_REG, 0);
        settle();
        checks++; if (alu_valid_o !== 1'b1 || alu_rd_o !== 5'd0) $display("FAIL x0_write_issue: got %0b/%0d want 1/0", alu_valid_o, alu_rd_o); else passes++;
        tick();
        dec_valid_i = 0; settle();
        checks++; if (alu_valid_o !== 1'b1 || alu_rd_o !== 5'd6 || alu_operand_a_o !== 32'd0)
            $display("FAIL x0_reader_no_stall: got %0b/%0d/%h want 1/6/0", alu_valid_o, alu_rd_o, alu_operand_a_o); else passes++;
        tick();
    endtask

    task automatic test_random();
        issue_entry_t mq[$];
        bit [NREG-1:0] msb;
        issue_entry_t h;
        int exp_cnt, errs;
        bit exp_av, exp_lv, blocked, src1, src2, issue;
        logic [XLEN-1:0] exp_a, exp_b;
        do_reset();
        msb = '0; errs = 0;
        rf[0] = 0;
        for (int i = 1; i < NREG; i++) rf[i] = $urandom;
        for (int cyc = 0; cyc < 800; cyc++) begin
            dec_valid_i = ($urandom_range(0, 9) < 6);
            h.rs1 = RW'($urandom_range(0, 7)); h.rs2 = RW'($urandom_range(0, 7)); h.rd = RW'($urandom_range(0, 7));
            h.we = $urandom_range(0, 1); h.unit = issue_unit_e'($urandom_range(0, 1));
            h.alu_op = alu_op_e'($urandom_range(0, 9)); h.sel_a = op_a_sel_e'($urandom_range(0, 2));
            h.sel_b = op_b_sel_e'($urandom_range(0, 1)); h.imm = $urandom; h.pc = $urandom;
            dec_entry_i = h;
            alu_ready_i = ($urandom_range(0, 9) < 7); lsu_ready_i = ($urandom_range(0, 9) < 7);
            wb_valid_i = ($urandom_range(0, 9) < 3); wb_rd_i = RW'($urandom_range(0, 7));
            flush_i = ($urandom_range(0, 99) < 3);
            settle();
            exp_cnt = mq.size(); exp_av = 0; exp_lv = 0; exp_a = 0; exp_b = 0; h = '0;
            if (exp_cnt != 0) begin
                h = mq[0];
                src1 = (h.unit == UNIT_LSU) ? 1'b1 : (h.sel_a == SEL_A_REG);
                src2 = (h.unit == UNIT_LSU) ? !h.we : (h.sel_b == SEL_B_REG);
                blocked = (src1 && msb[h.rs1]) || (src2 && msb[h.rs2]) || (h.we && msb[h.rd]);
                exp_av = !blocked && h.unit == UNIT_ALU;
                exp_lv = !blocked && h.unit == UNIT_LSU;
                exp_a = (h.sel_a == SEL_A_REG) ? rf[h.rs1] : (h.sel_a == SEL_A_PC) ? h.pc : 0;
                exp_b = (h.sel_b == SEL_B_IMM) ? h.imm : rf[h.rs2];
            end
            checks++; if (count_o !== 3'(exp_cnt) || dec_ready_o !== (exp_cnt != DEPTH))
                begin errs++; $display("FAIL rand_count c%0d: got %0d/%0b want %0d/%0b", cyc, count_o, dec_ready_o, exp_cnt, exp_cnt != DEPTH); end else passes++;
            checks++; if ({alu_valid_o, lsu_valid_o} !== {exp_av, exp_lv})
                begin errs++; $display("FAIL rand_valid c%0d: got %b want %b", cyc, {alu_valid_o, lsu_valid_o}, {exp_av, exp_lv}); end else passes++;
            checks++; if (dut.u_sb.busy_q !== msb)
                begin errs++; $display("FAIL rand_sb c%0d: got %h want %h", cyc, dut.u_sb.busy_q, msb); end else passes++;
            if (exp_av) begin
                checks++; if (alu_op_o !== h.alu_op || alu_operand_a_o !== exp_a || alu_operand_b_o !== exp_b || alu_rd_o !== h.rd)
                    begin errs++; $display("FAIL rand_alu c%0d: got %0d/%h/%h/%0d want %0d/%h/%h/%0d", cyc, alu_op_o, alu_operand_a_o, alu_operand_b_o, alu_rd_o, h.alu_op, exp_a, exp_b, h.rd); end else passes++;
            end
            if (exp_lv) begin
                checks++; if (lsu_base_o !== rf[h.rs1] || lsu_offset_o !== h.imm || lsu_wdata_o !== rf[h.rs2] || lsu_rd_o !== h.rd || lsu_we_o !== !h.we)
                    begin errs++; $display("FAIL rand_lsu c%0d: got %h/%h/%h/%0d/%0b", cyc, lsu_base_o, lsu_offset_o, lsu_wdata_o, lsu_rd_o, lsu_we_o); end else passes++;
            end
            if (errs > 20) break;
            issue = (exp_av && alu_ready_i) || (exp_lv && lsu_ready_i);
            tick();
            if (wb_valid_i && wb_rd_i != 0) msb[wb_rd_i] = 1'b0;
            if (issue && h.we && h.rd != 0) msb[h.rd] = 1'b1;
            if (flush_i) mq.delete();
            else begin
                if (issue) void'(mq.pop_front());
                if (dec_valid_i && exp_cnt != DEPTH) mq.push_back(dec_entry_i);
            end
        end
        flush_i = 0; dec_valid_i = 0; wb_valid_i = 0;
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) rf[i] = '0;
        test_reset();
        test_basic_add();
        test_raw();
        test_fill();
        test_lsu_store();
        test_flush();
        test_set_clear();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
# issue_queue

Parametrised in-order issue stage between decode and the execution units. It buffers up to DEPTH decoded instructions and tracks pending register writes in a scoreboard. It resolves operands (register file, PC, zero, immediate) for the head entry and dispatches one instruction per cycle to the ALU or LSU channel over valid/ready handshakes. It supersedes the single-shot request-driven issue block: it adds buffering, hazard stalls, flush and backpressure.

## Interface
- DEPTH, 4, queue entries; power of two, >= 2
- XLEN, 32, datapath width
- NREG, 32, architectural registers; index width RW = $clog2(NREG)

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  discard all queued entries
- dec_valid_i / dec_ready_o  in/out  1  decode push handshake
- dec_entry_i  in  pkg::issue_entry_t  rs1, rs2, rd, we, unit, alu_op, sel_a, sel_b, imm[XLEN-1:0], pc[XLEN-1:0]
- rf_raddr_a_o, rf_raddr_b_o  out  RW  head rs1/rs2, combinational
- rf_rdata_a_i, rf_rdata_b_i  in  XLEN  combinational RF read data
- alu_valid_o / alu_ready_i  out/in  1  ALU dispatch handshake
- alu_op_o  out  pkg::alu_op; alu_operand_a_o, alu_operand_b_o  out  XLEN; alu_rd_o  out  RW
- lsu_valid_o / lsu_ready_i  out/in  1  LSU dispatch handshake
- lsu_we_o  out  1; lsu_base_o, lsu_offset_o, lsu_wdata_o  out  XLEN; lsu_rd_o  out  RW
- wb_valid_i  in  1; wb_rd_i  in  RW  writeback completion, clears scoreboard bit
- count_o  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Circular buffer with rd/wr pointers and a count. Push when dec_valid_i && dec_ready_o. dec_ready_o = (count != DEPTH); it is registered-state only, with no same-cycle pop pass-through.
- Head is ready when count != 0, scoreboard[rs1] and scoreboard[rs2] are clear for any register operand used, and scoreboard[rd] is clear when we=1 (WAW stall). x0 is never busy.
- Operand A: SEL_A_REG = rf_rdata_a_i, SEL_A_PC = pc, SEL_A_ZERO = 0. Operand B: SEL_B_REG = rf_rdata_b_i, SEL_B_IMM = imm.
- LSU: lsu_base_o = rf_rdata_a_i, lsu_offset_o = imm, lsu_wdata_o = rf_rdata_b_i. Address arithmetic is done in the LSU.
- Only the channel selected by head.unit asserts valid. The other channel's valid stays 0, and its data outputs are don't-care.
- Issue occurs when the selected channel sees valid && ready. It pops the head and sets scoreboard[rd] if we=1 and rd != 0.
- wb_valid_i clears scoreboard[wb_rd_i]. Clearing x0 is a no-op.
- Set and clear of the same register in one cycle: set wins.
- Push and pop in the same cycle: count unchanged, pointers both advance.
- flush_i: pointers and count go to 0 next cycle, and any push that cycle is dropped. The scoreboard is kept, because in-flight writebacks still return. Valid may drop on flush without ready.
- Outside flush, a valid channel holds its valid and data stable until ready. Head and scoreboard bits for its operands cannot change meanwhile.

## Timing
- Reset: count_o=0, pointers 0, scoreboard all 0, alu_valid_o=0, lsu_valid_o=0, dec_ready_o=1. rf_raddr_* = 0 and other data outputs = 0 while empty.
- Push to earliest dispatch: 1 cycle. An entry pushed in cycle N is visible at the head in N+1.
- Throughput: 1 issue per cycle with no hazards.
- Scoreboard is registered. A hazard set by issue in cycle N blocks a dependent head in N+1. A clear from wb_valid_i in cycle N unblocks in N+1.
- Pointer wrap: DEPTH-1 -> 0 via natural overflow of a $clog2(DEPTH)-bit pointer.
- Reset mid-operation: all entries and scoreboard state are lost, and outputs return to reset values the next cycle.

## Structure
- Shared pkg: issue_unit_e {UNIT_ALU, UNIT_LSU}, op_a_sel_e {SEL_A_REG, SEL_A_PC, SEL_A_ZERO}, op_b_sel_e {SEL_B_REG, SEL_B_IMM}, issue_entry_t packed struct (XLEN as pkg constant). alu_op stays in pkg.
- Sub-module issue_scoreboard (NREG): set/clear ports, two source busy queries plus a dest busy query, x0 hardwired clear.
- The top holds the FIFO storage, the operand mux and the dispatch steering.

## Test plan
- Reset, then push ADD x3=x1+x2 (rf_a=5, rf_b=7, ready=1): alu_valid_o in the cycle after push, operands 5/7, alu_rd_o=3, scoreboard[3]=1.
- RAW: push ADD rd=x3, then SUB rs1=x3. The SUB stalls until wb_valid_i with wb_rd_i=3 in cycle K, and issues in K+1.
- Fill with DEPTH=4 entries while alu_ready_i=0: dec_ready_o=0, count_o=4. A 5th push is ignored. Raising ready drains in order, 1 per cycle.
- LSU store (sel imm=0x10, rf_a=0x1000, rf_b=0xAB, we=0): lsu_valid_o=1, base 0x1000, offset 0x10, wdata 0xAB, no scoreboard set, alu_valid_o stays 0.
- flush_i with 3 entries plus a simultaneous push: count_o=0 next cycle, both valids 0, pending scoreboard bits unchanged.
- Same-cycle issue of rd=x5 and wb_valid_i for x5: scoreboard[5]=1 afterwards. rd=x0 never stalls a later reader of x0.
